// File: rtl/piso_scan_ctrl.sv
// Scan sequencer for a daisy chain of 74165 PISO shift registers: load, shift out 8*CHAINS bits, publish word.
// Optional continuous rescanning is enabled by defining SCAN_AUTO_EN, which adds the auto input.
module piso_scan_ctrl #(
    parameter int CHAINS = 2,
    parameter int DIV    = 2
) (
    input  logic                  cp,
    input  logic                  mr,
    input  logic                  start,
`ifdef SCAN_AUTO_EN
    input  logic                  auto,
`endif
    input  logic                  sr_q7,
    output logic                  busy,
    output logic                  done,
    output logic [8*CHAINS-1:0]   data,
    output logic                  sr_n_pl,
    output logic                  sr_cp,
    output logic                  sr_n_ce
);

    localparam int N  = 8 * CHAINS;
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = $clog2(N);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT_LO,
        SHIFT_HI,
        DONE
    } state_t;

    state_t          state, state_nx;
    logic [PW-1:0]   phase, phase_nx;
    logic [BW-1:0]   bit_cnt, bit_nx;
    logic [N-1:0]    acc, acc_nx;
    logic            phase_last;

    assign phase_last = (phase == PW'(DIV - 1));

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        state_nx = state;
        phase_nx = phase;
        bit_nx   = bit_cnt;
        acc_nx   = acc;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = LOAD;
                    phase_nx = '0;
                    bit_nx   = '0;
                end
            end
            LOAD: begin
                if (phase_last) begin
                    state_nx = SHIFT_LO;
                    phase_nx = '0;
                end else begin
                    phase_nx = phase + PW'(1);
                end
            end
            SHIFT_LO: begin
                if (phase_last) begin
                    // Sample q7 at the end of the low phase, after the chain has settled.
                    acc_nx   = {acc[N-2:0], sr_q7};
                    bit_nx   = bit_cnt + BW'(1);
                    phase_nx = '0;
                    state_nx = (bit_cnt == BW'(N - 1)) ? DONE : SHIFT_HI;
                end else begin
                    phase_nx = phase + PW'(1);
                end
            end
            SHIFT_HI: begin
                if (phase_last) begin
                    state_nx = SHIFT_LO;
                    phase_nx = '0;
                end else begin
                    phase_nx = phase + PW'(1);
                end
            end
            DONE: begin
                phase_nx = '0;
                bit_nx   = '0;
`ifdef SCAN_AUTO_EN
                state_nx = auto ? LOAD : IDLE;
`else
                state_nx = IDLE;
`endif
            end
            default: state_nx = IDLE;
        endcase
    end

    // Pin-side outputs are decoded from the next state so they come straight from flops yet track the state.
    always_ff @(posedge cp or posedge mr) begin
        if (mr) begin
            state   <= IDLE;
            phase   <= '0;
            bit_cnt <= '0;
            acc     <= '0;
            data    <= '0;
            sr_n_pl <= 1'b1;
            sr_cp   <= 1'b0;
            sr_n_ce <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
            state   <= state_nx;
            phase   <= phase_nx;
            bit_cnt <= bit_nx;
            acc     <= acc_nx;
            sr_n_pl <= (state_nx != LOAD);
            sr_cp   <= (state_nx == SHIFT_HI);
            sr_n_ce <= !((state_nx == SHIFT_LO) || (state_nx == SHIFT_HI));
            busy    <= (state_nx != IDLE);
            done    <= (state_nx == DONE);
            if (state_nx == DONE) begin
                data <= acc_nx;
            end
        end
    end

endmodule

// File: tb/tb_piso_scan_ctrl.sv
// Directed bench for piso_scan_ctrl: a 16-bit (DIV=2) and an 8-bit (DIV=1) instance, each with a 74165 chain model.
module tb_piso_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        mr;
    logic        start_a, start_b;
    logic [15:0] d_a;
    logic [7:0]  d_b;
    logic [15:0] sh_a = '0;
    logic [7:0]  sh_b = '0;
    logic        q7_a, q7_b;
    logic        busy_a, done_a, n_pl_a, cp_a, n_ce_a;
    logic        busy_b, done_b, n_pl_b, cp_b, n_ce_b;
    logic [15:0] data_a;
    logic [7:0]  data_b;
    logic        cp_a_q = 1'b0, cp_b_q = 1'b0;
    int          rises_a = 0, rises_b = 0;
    int          viol_a = 0, viol_b = 0;
    int          total = 0, bad = 0;
`ifdef SCAN_AUTO_EN
    logic        auto_a, auto_b;
`endif

    piso_scan_ctrl #(.CHAINS(2), .DIV(2)) u_dut16 (
        .cp(clk), .mr(mr), .start(start_a),
`ifdef SCAN_AUTO_EN
        .auto(auto_a),
`endif
        .sr_q7(q7_a), .busy(busy_a), .done(done_a), .data(data_a),
        .sr_n_pl(n_pl_a), .sr_cp(cp_a), .sr_n_ce(n_ce_a)
    );

    piso_scan_ctrl #(.CHAINS(1), .DIV(1)) u_dut8 (
        .cp(clk), .mr(mr), .start(start_b),
`ifdef SCAN_AUTO_EN
        .auto(auto_b),
`endif
        .sr_q7(q7_b), .busy(busy_b), .done(done_b), .data(data_b),
        .sr_n_pl(n_pl_b), .sr_cp(cp_b), .sr_n_ce(n_ce_b)
    );

    // 74165 chain models, evaluated mid-cycle once the registered pins are stable.
    assign q7_a = sh_a[15];
    assign q7_b = sh_b[7];

    always @(negedge clk) begin
        if (!n_pl_a) sh_a <= d_a;
        else if (cp_a && !cp_a_q && !n_ce_a) sh_a <= {sh_a[14:0], 1'b0};
        if (cp_a && !cp_a_q) rises_a <= rises_a + 1;
        if (!n_pl_a && !n_ce_a) viol_a <= viol_a + 1;
        cp_a_q <= cp_a;
    end

    always @(negedge clk) begin
        if (!n_pl_b) sh_b <= d_b;
        else if (cp_b && !cp_b_q && !n_ce_b) sh_b <= {sh_b[6:0], 1'b0};
        if (cp_b && !cp_b_q) rises_b <= rises_b + 1;
        if (!n_pl_b && !n_ce_b) viol_b <= viol_b + 1;
        cp_b_q <= cp_b;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until the selected done is high; n is the cycle index relative to the start edge.
    task automatic wait_done(input bit sel_b, inout int n);
        while (!(sel_b ? done_b : done_a) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) check("done_timeout", 32'(n), 32'd0);
    endtask

    initial begin
        int n;
        int r0;
        int extra;
        mr = 1'b0; start_a = 1'b0; start_b = 1'b0;
        d_a = 16'hA55A; d_b = 8'h81;
`ifdef SCAN_AUTO_EN
        auto_a = 1'b0; auto_b = 1'b0;
`endif
        #2 mr = 1'b1;
        #10;
        check("rst_n_pl",  32'(n_pl_a), 32'd1);
        check("rst_cp",    32'(cp_a),   32'd0);
        check("rst_n_ce",  32'(n_ce_a), 32'd1);
        check("rst_busy",  32'(busy_a), 32'd0);
        check("rst_done",  32'(done_a), 32'd0);
        check("rst_data",  32'(data_a), 32'd0);
        check("rst_data8", 32'(data_b), 32'd0);
        @(negedge clk) mr = 1'b0;
        tick();

        // Full 16-bit scan, DIV=2.
        r0 = rises_a;
        start_a = 1'b1; tick(); start_a = 1'b0; n = 1;
        check("load_pl_low", 32'(n_pl_a), 32'd0);
        check("load_busy",   32'(busy_a), 32'd1);
        wait_done(1'b0, n);
        check("a55a_latency", 32'(n), 32'd65);
        check("a55a_data",    32'(data_a), 32'h0000A55A);
        check("a55a_busy_dn", 32'(busy_a), 32'd1);
        tick();
        check("a55a_rises",   32'(rises_a - r0), 32'd15);
        check("a55a_idle_busy", 32'(busy_a), 32'd0);
        check("a55a_done_pulse", 32'(done_a), 32'd0);
        check("a55a_hold",    32'(data_a), 32'h0000A55A);

        // 8-bit scan, DIV=1.
        r0 = rises_b;
        start_b = 1'b1; tick(); start_b = 1'b0; n = 1;
        check("b_load_pl_low", 32'(n_pl_b), 32'd0);
        wait_done(1'b1, n);
        check("b81_latency", 32'(n), 32'd17);
        check("b81_data",    32'(data_b), 32'h81);
        tick();
        check("b81_rises",   32'(rises_b - r0), 32'd7);
        check("b81_busy",    32'(busy_b), 32'd0);

        // start re-pulsed in SHIFT_LO of bit 5 must be ignored.
        d_a = 16'h3C96;
        start_a = 1'b1; tick(); start_a = 1'b0; n = 1;
        repeat (22) begin tick(); n++; end
        check("mid_shift_lo", 32'(n_ce_a), 32'd0);
        start_a = 1'b1; tick(); n++; start_a = 1'b0;
        wait_done(1'b0, n);
        check("restart_latency", 32'(n), 32'd65);
        check("restart_data",    32'(data_a), 32'h00003C96);
        extra = 0;
        repeat (80) begin tick(); if (done_a) extra++; end
        check("restart_no_extra_done", 32'(extra), 32'd0);
        check("restart_idle", 32'(busy_a), 32'd0);

        // mr during SHIFT_HI after bit 9.
        d_a = 16'hC3E1;
        start_a = 1'b1; tick(); start_a = 1'b0;
        repeat (40) tick();
        check("mr_in_shift_hi", 32'(cp_a), 32'd1);
        mr = 1'b1; #1;
        check("mr_n_pl", 32'(n_pl_a), 32'd1);
        check("mr_cp",   32'(cp_a),   32'd0);
        check("mr_n_ce", 32'(n_ce_a), 32'd1);
        check("mr_busy", 32'(busy_a), 32'd0);
        check("mr_data", 32'(data_a), 32'd0);
        #1 mr = 1'b0;
        extra = 0;
        repeat (70) begin tick(); if (done_a) extra++; end
        check("mr_no_done", 32'(extra), 32'd0);
        start_a = 1'b1; tick(); start_a = 1'b0; n = 1;
        wait_done(1'b0, n);
        check("post_mr_latency", 32'(n), 32'd65);
        check("post_mr_data",    32'(data_a), 32'h0000C3E1);
        tick();

        // Parallel inputs changed after the load is latched.
        d_a = 16'h0000;
        start_a = 1'b1; tick(); start_a = 1'b0; n = 1;
        repeat (14) begin tick(); n++; end
        check("dchg_in_shift_lo", 32'({n_ce_a, cp_a}), 32'd0);
        d_a = 16'hFFFF;
        wait_done(1'b0, n);
        check("dchg_latency", 32'(n), 32'd65);
        check("dchg_data",    32'(data_a), 32'h00000000);
        tick();

`ifdef SCAN_AUTO_EN
        // Continuous rescanning with alternating parallel data.
        d_a = 16'h1234; auto_a = 1'b1;
        start_a = 1'b1; tick(); start_a = 1'b0; n = 1;
        wait_done(1'b0, n);
        check("auto0_data", 32'(data_a), 32'h00001234);
        d_a = 16'h4321; tick(); n = 1;
        wait_done(1'b0, n);
        check("auto1_period", 32'(n), 32'd65);
        check("auto1_data",   32'(data_a), 32'h00004321);
        check("auto1_busy",   32'(busy_a), 32'd1);
        d_a = 16'h1234; tick(); n = 1;
        check("auto_busy_held", 32'(busy_a), 32'd1);
        wait_done(1'b0, n);
        check("auto2_period", 32'(n), 32'd65);
        check("auto2_data",   32'(data_a), 32'h00001234);
        d_a = 16'h4321; tick(); n = 1;
        auto_a = 1'b0;
        wait_done(1'b0, n);
        check("auto3_period", 32'(n), 32'd65);
        check("auto3_data",   32'(data_a), 32'h00004321);
        tick();
        check("auto_off_idle", 32'(busy_a), 32'd0);
`endif

        check("pl_ce_excl_a", 32'(viol_a), 32'd0);
        check("pl_ce_excl_b", 32'(viol_b), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
